// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor state for the traffic signal monitor.
package traffic_pkg;

  localparam int unsigned LAMP_W = 3;

  localparam logic [LAMP_W-1:0] LAMP_RED    = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_GREEN  = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_OFF    = 3'b000;

  typedef enum logic [1:0] {
    FAULT_NONE         = 2'b00,
    FAULT_INVALID      = 2'b01,
    FAULT_CONFLICT     = 2'b10,
    FAULT_SHORT_YELLOW = 2'b11
  } fault_code_e;

  typedef enum logic {
    ST_MONITOR = 1'b0,
    ST_FAULT   = 1'b1
  } mon_state_e;

  // A legal aspect is exactly one lamp lit.
  function automatic logic lamp_valid(input logic [LAMP_W-1:0] aspect);
    return (aspect == LAMP_RED) || (aspect == LAMP_YELLOW) || (aspect == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/traffic_signal_monitor_lamp_flasher.sv
// Fault flash timing. on_phase is the phase the lamps take at the next edge; while disabled
// the counter sits preloaded so the first half-period after enable rises is the on phase.
module lamp_flasher #(
  parameter int unsigned HALF_PERIOD = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic on_phase
);

  localparam int unsigned   CW          = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_PRELOAD = CW'((HALF_PERIOD > 1) ? 1 : 0);
  localparam logic          ON_PRELOAD  = (HALF_PERIOD > 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= CNT_PRELOAD;
      on_phase <= ON_PRELOAD;
    end else if (!enable) begin
      r_cnt    <= CNT_PRELOAD;
      on_phase <= ON_PRELOAD;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      on_phase <= ~on_phase;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Safety stage between the controller and the lamps: passes legal aspects, latches faults and
// flashes red until cleared. `define MONITOR_YELLOW_CHECK_EN adds the short-yellow check.
module traffic_signal_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_YELLOW_CYCLES = 3,
  parameter int unsigned FLASH_HALF_PERIOD = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_main,
  input  logic [2:0] light_side,
  input  logic       fault_clear,
  output logic [2:0] lamp_main,
  output logic [2:0] lamp_side,
  output logic       fault,
  output logic [1:0] fault_code
);

  mon_state_e  r_state;
  fault_code_e w_cause;
  logic        w_valid;
  logic        w_conflict;
  logic        w_short;
  logic        w_exit;
  logic        w_on_phase;

`ifdef MONITOR_YELLOW_CHECK_EN
  localparam int unsigned   YW    = (MIN_YELLOW_CYCLES > 0) ? $clog2(MIN_YELLOW_CYCLES + 1) : 1;
  localparam logic [YW-1:0] Y_MIN = YW'(MIN_YELLOW_CYCLES);

  logic [YW-1:0] r_ycnt_main;
  logic [YW-1:0] r_ycnt_side;
  logic          r_prev_y_main;
  logic          r_prev_y_side;
  logic          w_y_main;
  logic          w_y_side;

  assign w_y_main = (light_main == LAMP_YELLOW);
  assign w_y_side = (light_side == LAMP_YELLOW);

  // Leaving yellow early, or straight to green, is a short yellow.
  assign w_short =
      (r_prev_y_main && !w_y_main && ((light_main == LAMP_GREEN) || (r_ycnt_main < Y_MIN))) ||
      (r_prev_y_side && !w_y_side && ((light_side == LAMP_GREEN) || (r_ycnt_side < Y_MIN)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ycnt_main   <= '0;
      r_ycnt_side   <= '0;
      r_prev_y_main <= 1'b0;
      r_prev_y_side <= 1'b0;
    end else begin
      r_prev_y_main <= w_y_main;
      r_prev_y_side <= w_y_side;
      if (r_state == ST_MONITOR && w_cause == FAULT_NONE) begin
        r_ycnt_main <= !w_y_main ? '0 : (r_ycnt_main == Y_MIN) ? r_ycnt_main : r_ycnt_main + YW'(1);
        r_ycnt_side <= !w_y_side ? '0 : (r_ycnt_side == Y_MIN) ? r_ycnt_side : r_ycnt_side + YW'(1);
      end else if (r_state == ST_FAULT && w_exit) begin
        r_ycnt_main <= YW'(w_y_main);
        r_ycnt_side <= YW'(w_y_side);
      end else begin
        r_ycnt_main <= '0;
        r_ycnt_side <= '0;
      end
    end
  end
`else
  assign w_short = 1'b0;
`endif

  always_comb begin
    w_valid    = lamp_valid(light_main) && lamp_valid(light_side);
    w_conflict = w_valid && (light_main != LAMP_RED) && (light_side != LAMP_RED);
    w_exit     = fault_clear && w_valid && !w_conflict;
    w_cause    = FAULT_NONE;
    if (!w_valid)        w_cause = FAULT_INVALID;
    else if (w_conflict) w_cause = FAULT_CONFLICT;
    else if (w_short)    w_cause = FAULT_SHORT_YELLOW;
  end

  lamp_flasher #(
    .HALF_PERIOD(FLASH_HALF_PERIOD)
  ) u_flasher (
    .clk     (clk),
    .reset   (reset),
    .enable  (r_state == ST_FAULT),
    .on_phase(w_on_phase)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_MONITOR;
      lamp_main  <= LAMP_RED;
      lamp_side  <= LAMP_RED;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      case (r_state)
        ST_MONITOR: begin
          if (w_cause != FAULT_NONE) begin
            r_state    <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= w_cause;
            lamp_main  <= LAMP_RED;
            lamp_side  <= LAMP_RED;
          end else begin
            lamp_main <= light_main;
            lamp_side <= light_side;
          end
        end
        ST_FAULT: begin
          if (w_exit) begin
            r_state    <= ST_MONITOR;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            lamp_main  <= light_main;
            lamp_side  <= light_side;
          end else begin
            lamp_main <= w_on_phase ? LAMP_RED : LAMP_OFF;
            lamp_side <= w_on_phase ? LAMP_RED : LAMP_OFF;
          end
        end
        default: r_state <= ST_MONITOR;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed scoreboard bench for traffic_signal_monitor (default parameters); expectations
// follow MONITOR_YELLOW_CHECK_EN when it is defined.
module tb_traffic_signal_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic       fault_clear;
  logic [2:0] lamp_main;
  logic [2:0] lamp_side;
  logic       fault;
  logic [1:0] fault_code;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  traffic_signal_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .light_main (light_main),
    .light_side (light_side),
    .fault_clear(fault_clear),
    .lamp_main  (lamp_main),
    .lamp_side  (lamp_side),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [2:0] em, input logic [2:0] es,
                      input logic ef, input logic [1:0] ec);
    exp_t e;
    e.tag = tag;
    e.v   = {em, es, ef, ec};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [8:0] obs;
    obs = {lamp_main, lamp_side, fault, fault_code};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %b required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed lm=%b ls=%b f=%b code=%b required lm=%b ls=%b f=%b code=%b",
               e.tag, obs[8:6], obs[5:3], obs[2], obs[1:0], e.v[8:6], e.v[5:3], e.v[2], e.v[1:0]);
      end
    end
  endtask

  task automatic step(input logic [2:0] m, input logic [2:0] s, input logic clr,
                      input logic [2:0] em, input logic [2:0] es, input logic ef,
                      input logic [1:0] ec, input string tag);
    @(negedge clk);
    light_main  = m;
    light_side  = s;
    fault_clear = clr;
    push(tag, em, es, ef, ec);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    logic [2:0] fl;
    reset       = 1'b1;
    light_main  = 3'b100;
    light_side  = 3'b100;
    fault_clear = 1'b0;
    #3;
    push("reset_during", 3'b100, 3'b100, 1'b0, 2'b00);
    pop_check();
    #7;
    reset = 1'b0;
    #1;
    push("reset_after", 3'b100, 3'b100, 1'b0, 2'b00);
    pop_check();

    // legal main cycle with a full 3-cycle yellow
    step(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, "pass_main_green");
    for (int i = 0; i < 3; i++)
      step(3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 2'b00, "pass_main_yellow");
    step(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00, "pass_side_green");
    for (int i = 0; i < 3; i++)
      step(3'b100, 3'b010, 1'b0, 3'b100, 3'b010, 1'b0, 2'b00, "pass_side_yellow");
    step(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, "pass_side_red");

    // conflict, then flash timing with inputs still conflicting
    step(3'b001, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 2'b10, "conflict_entry");
    for (int k = 1; k <= 10; k++) begin
      fl = (((k / 5) % 2) == 0) ? 3'b100 : 3'b000;
      step(3'b001, 3'b001, 1'b0, fl, fl, 1'b1, 2'b10, "flash_phase");
    end
    step(3'b100, 3'b001, 1'b1, 3'b100, 3'b001, 1'b0, 2'b00, "conflict_exit");

    // invalid code; clears refused while still illegal; code held against a later conflict
    step(3'b011, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 2'b01, "invalid_entry");
    step(3'b011, 3'b001, 1'b1, 3'b100, 3'b100, 1'b1, 2'b01, "clear_ignored_invalid");
    step(3'b001, 3'b001, 1'b1, 3'b100, 3'b100, 1'b1, 2'b01, "clear_ignored_conflict");
    step(3'b100, 3'b001, 1'b1, 3'b100, 3'b001, 1'b0, 2'b00, "invalid_exit");

    // invalid outranks a simultaneous short yellow on the other road
    step(3'b100, 3'b010, 1'b0, 3'b100, 3'b010, 1'b0, 2'b00, "prio_side_yellow");
    step(3'b110, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 2'b01, "prio_invalid");
    step(3'b100, 3'b001, 1'b1, 3'b100, 3'b001, 1'b0, 2'b00, "prio_exit");

    // main yellow only 2 cycles then red
    step(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, "sy_green");
    step(3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 2'b00, "sy_yellow1");
    step(3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 2'b00, "sy_yellow2");
`ifdef MONITOR_YELLOW_CHECK_EN
    step(3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 2'b11, "short_yellow_red");
`else
    step(3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00, "short_yellow_red");
`endif
    step(3'b100, 3'b001, 1'b1, 3'b100, 3'b001, 1'b0, 2'b00, "sy_exit");

    // full-length yellow straight to green
    step(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, "yg_green");
    for (int i = 0; i < 3; i++)
      step(3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 2'b00, "yg_yellow");
`ifdef MONITOR_YELLOW_CHECK_EN
    step(3'b001, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 2'b11, "yellow_to_green");
`else
    step(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, "yellow_to_green");
`endif
    step(3'b100, 3'b001, 1'b1, 3'b100, 3'b001, 1'b0, 2'b00, "yg_exit");

    // asynchronous reset in the off phase of a flash
    step(3'b001, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 2'b10, "rst_conflict_entry");
    for (int k = 1; k <= 6; k++) begin
      fl = (k < 5) ? 3'b100 : 3'b000;
      step(3'b001, 3'b001, 1'b0, fl, fl, 1'b1, 2'b10, "rst_flash");
    end
    #2;
    reset = 1'b1;
    #1;
    push("async_reset", 3'b100, 3'b100, 1'b0, 2'b00);
    pop_check();
    @(negedge clk);
    light_main = 3'b001;
    light_side = 3'b100;
    reset      = 1'b0;
    step(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, "post_reset_pass");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
